// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types for the pipeline hazard controller
//               (forwarding select encoding, controller FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Operand source selected in front of the execute-stage ALU
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // Memory handshake tracking
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Bundle between the 5-stage pipeline datapath (master) and
//               the hazard controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    // Pipeline status
    logic [REG_AW-1:0] raddr1D;
    logic [REG_AW-1:0] raddr2D;
    logic [REG_AW-1:0] raddr1E;
    logic [REG_AW-1:0] raddr2E;
    logic [REG_AW-1:0] waddrE;
    logic [REG_AW-1:0] waddrM;
    logic [REG_AW-1:0] waddrW;
    logic              reg_wrE;
    logic              reg_wrM;
    logic              reg_wrW;
    logic              is_loadE;
    logic              br_takenE;
    logic              mem_reqM;
    logic              mem_ack;

    // Hazard control
    logic [1:0]        forwardAE;
    logic [1:0]        forwardBE;
    logic              stallF;
    logic              stallD;
    logic              stallE;
    logic              stallM;
    logic              flushD;
    logic              flushE;
    logic              flushW;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    modport master (
        output raddr1D, raddr2D, raddr1E, raddr2E,
        output waddrE, waddrM, waddrW, reg_wrE, reg_wrM, reg_wrW,
        output is_loadE, br_takenE, mem_reqM, mem_ack,
        input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushW, mem_err, stall_cycles, flush_events
    );

    modport slave (
        input  raddr1D, raddr2D, raddr1E, raddr2E,
        input  waddrE, waddrM, waddrW, reg_wrE, reg_wrM, reg_wrW,
        input  is_loadE, br_takenE, mem_reqM, mem_ack,
        output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
        output flushD, flushE, flushW, mem_err, stall_cycles, flush_events
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Forwarding select for one execute-stage source operand.
//               M-stage result wins over W-stage result; x0 never forwards.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] waddr_m,
    input  logic              reg_wr_m,
    input  logic [REG_AW-1:0] waddr_w,
    input  logic              reg_wr_w,
    output fwd_sel_e          sel
);

    // Pick the youngest in-flight producer of this source register
    always_comb begin
        sel = FWD_RF;
        if (src != '0) begin
            if (reg_wr_m && (waddr_m == src)) begin
                sel = FWD_M;
            end else if (reg_wr_w && (waddr_w == src)) begin
                sel = FWD_W;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard controller for the 5-stage RV32I pipeline: operand
//               forwarding (or stall-only interlock), load-use stalls, branch
//               flushes, variable-latency data memory hold with timeout, and
//               saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    hz_state_e         state;
    hz_state_e         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;

    fwd_sel_e          sel_a;
    fwd_sel_e          sel_b;
    logic              load_use;
    logic              interlock_raw;
    logic              raw_d;
    logic              abandon;
    logic              memstall;
    logic              br_flush;
    logic              stall_inc;

    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              mem_err_q;

    // True when a decode source reads a register an older stage will write
    function automatic logic dest_hit(input logic [REG_AW-1:0] src,
                                      input logic [REG_AW-1:0] waddr,
                                      input logic              wr);
        return wr && (src != '0) && (waddr == src);
    endfunction

    if (FWD_EN != 0) begin : g_fwd
        fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
            .src      (hz.raddr1E),
            .waddr_m  (hz.waddrM),
            .reg_wr_m (hz.reg_wrM),
            .waddr_w  (hz.waddrW),
            .reg_wr_w (hz.reg_wrW),
            .sel      (sel_a)
        );
        fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
            .src      (hz.raddr2E),
            .waddr_m  (hz.waddrM),
            .reg_wr_m (hz.reg_wrM),
            .waddr_w  (hz.waddrW),
            .reg_wr_w (hz.reg_wrW),
            .sel      (sel_b)
        );
        assign interlock_raw = 1'b0;
    end else begin : g_nofwd
        // Without bypass paths (and no register-file write-through) any
        // pending writer of a decode source must drain through W first
        assign sel_a = FWD_RF;
        assign sel_b = FWD_RF;
        assign interlock_raw =
            dest_hit(hz.raddr1D, hz.waddrE, hz.reg_wrE) ||
            dest_hit(hz.raddr2D, hz.waddrE, hz.reg_wrE) ||
            dest_hit(hz.raddr1D, hz.waddrM, hz.reg_wrM) ||
            dest_hit(hz.raddr2D, hz.waddrM, hz.reg_wrM) ||
            dest_hit(hz.raddr1D, hz.waddrW, hz.reg_wrW) ||
            dest_hit(hz.raddr2D, hz.waddrW, hz.reg_wrW);
    end

    assign load_use = hz.is_loadE && hz.reg_wrE && (hz.waddrE != '0) &&
                      ((hz.waddrE == hz.raddr1D) || (hz.waddrE == hz.raddr2D));
    assign raw_d    = load_use || interlock_raw;

    // The last permitted wait cycle without an ack gives up on the access
    assign abandon  = (state == MEM_WAIT) && !hz.mem_ack && (wait_cnt == WAIT_MAX);
    assign memstall = hz.mem_reqM && !hz.mem_ack && !abandon;
    assign br_flush = rst && hz.br_takenE && !memstall;
    assign stall_inc = rst && (memstall || (raw_d && !hz.br_takenE));

    // FSM state and wait counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Memory handshake next-state logic
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (hz.mem_reqM && !hz.mem_ack) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ack || abandon) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_ONE;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Stall/flush/forward outputs, priority memstall > branch > RAW
    always_comb begin
        hz.forwardAE = FWD_RF;
        hz.forwardBE = FWD_RF;
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.stallM    = 1'b0;
        hz.flushD    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushW    = 1'b0;
        if (rst) begin
            hz.forwardAE = sel_a;
            hz.forwardBE = sel_b;
            if (memstall) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.stallE = 1'b1;
                hz.stallM = 1'b1;
                hz.flushW = 1'b1;
            end else if (hz.br_takenE) begin
                hz.flushD = 1'b1;
                hz.flushE = 1'b1;
            end else if (raw_d) begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.flushE = 1'b1;
            end
        end
    end

    // Timeout error pulse and saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_err_q <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            mem_err_q <= abandon;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (br_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_events = flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed testbench: forwarding DUT (MEM_TIMEOUT=4) and
//               stall-only DUT (MEM_TIMEOUT=16) driven with identical inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic [4:0] r1D, r2D, r1E, r2E, wE, wM, wW;
        logic       wrE, wrM, wrW, ld, br;
        logic [1:0] fa, fb;
        logic       sF, fD, fE;
        logic       s1;     // expected stallF of the stall-only DUT
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    vec_t vecs[13];

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz0 ();
    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz1 ();

    pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut0 (
        .clk (clk),
        .rst (rst),
        .hz  (hz0.slave)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(16), .CNT_W(32)) dut1 (
        .clk (clk),
        .rst (rst),
        .hz  (hz1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkv(input int r1D, r2D, r1E, r2E, wE, wM, wW,
                                 input int wrE, wrM, wrW, ld, br,
                                 input int fa, fb, sF, fD, fE, s1);
        vec_t v;
        v.r1D = 5'(r1D); v.r2D = 5'(r2D); v.r1E = 5'(r1E); v.r2E = 5'(r2E);
        v.wE  = 5'(wE);  v.wM  = 5'(wM);  v.wW  = 5'(wW);
        v.wrE = 1'(wrE); v.wrM = 1'(wrM); v.wrW = 1'(wrW);
        v.ld  = 1'(ld);  v.br  = 1'(br);
        v.fa  = 2'(fa);  v.fb  = 2'(fb);
        v.sF  = 1'(sF);  v.fD  = 1'(fD);  v.fE  = 1'(fE); v.s1 = 1'(s1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hz0.raddr1D = v.r1D; hz0.raddr2D = v.r2D; hz0.raddr1E = v.r1E; hz0.raddr2E = v.r2E;
        hz0.waddrE = v.wE; hz0.waddrM = v.wM; hz0.waddrW = v.wW;
        hz0.reg_wrE = v.wrE; hz0.reg_wrM = v.wrM; hz0.reg_wrW = v.wrW;
        hz0.is_loadE = v.ld; hz0.br_takenE = v.br;
        hz1.raddr1D = v.r1D; hz1.raddr2D = v.r2D; hz1.raddr1E = v.r1E; hz1.raddr2E = v.r2E;
        hz1.waddrE = v.wE; hz1.waddrM = v.wM; hz1.waddrW = v.wW;
        hz1.reg_wrE = v.wrE; hz1.reg_wrM = v.wrM; hz1.reg_wrW = v.wrW;
        hz1.is_loadE = v.ld; hz1.br_takenE = v.br;
    endtask

    task automatic set_mem(input logic req, input logic ack);
        hz0.mem_reqM = req; hz0.mem_ack = ack;
        hz1.mem_reqM = req; hz1.mem_ack = ack;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, " stall_cycles"}, hz0.stall_cycles, 32'(exp_stall));
        chk({tag, " flush_events"}, hz0.flush_events, 32'(exp_flush));
    endtask

    initial begin
        //            r1D r2D r1E r2E wE wM wW wrE wrM wrW ld br fa fb sF fD fE s1
        vecs[0]  = mkv(0,  0,  5,  0,  0, 5, 5,  0,  1,  1, 0, 0, 2, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(0,  0,  5,  0,  0, 5, 5,  0,  0,  1, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(0,  0,  0,  0,  0, 0, 0,  0,  1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(0,  0,  4,  9,  0, 9, 4,  0,  1,  1, 0, 0, 1, 2, 0, 0, 0, 0);
        vecs[4]  = mkv(0,  7,  0,  0,  7, 0, 0,  1,  0,  0, 1, 0, 0, 0, 1, 0, 1, 1);
        vecs[5]  = mkv(0,  7,  0,  0,  7, 0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mkv(0,  0,  0,  0,  0, 0, 0,  1,  0,  0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mkv(3,  0,  3,  0,  0, 0, 3,  0,  0,  1, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[8]  = mkv(0,  7,  0,  0,  7, 0, 0,  1,  0,  0, 1, 1, 0, 0, 0, 1, 1, 0);
        vecs[9]  = mkv(6,  0,  0,  0,  6, 0, 0,  1,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[10] = mkv(0, 12,  0,  0,  0,12, 0,  0,  1,  0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[11] = mkv(0,  0,  0,  0,  0, 0, 0,  0,  0,  0, 0, 1, 0, 0, 0, 1, 1, 0);
        vecs[12] = mkv(0,  0,  8,  8,  0, 8, 8,  0,  1,  1, 0, 0, 2, 2, 0, 0, 0, 0);

        // Reset with active requests: outputs forced low, registers cleared
        rst = 1'b0;
        drive(mkv(0, 7, 5, 0, 7, 5, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        set_mem(1'b1, 1'b0);
        @(negedge clk);
        chk("reset stallF", hz0.stallF, 0);
        chk("reset flushE", hz0.flushE, 0);
        chk("reset flushW", hz0.flushW, 0);
        chk("reset forwardAE", hz0.forwardAE, 0);
        next_cycle();
        chk("reset mem_err", hz0.mem_err, 0);
        chk_counters("reset");
        rst = 1'b1;
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        set_mem(1'b0, 1'b0);
        next_cycle();

        // Single-cycle combinational vectors
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d forwardAE", i), hz0.forwardAE, vecs[i].fa);
            chk($sformatf("v%0d forwardBE", i), hz0.forwardBE, vecs[i].fb);
            chk($sformatf("v%0d stallF", i), hz0.stallF, vecs[i].sF);
            chk($sformatf("v%0d stallD", i), hz0.stallD, vecs[i].sF);
            chk($sformatf("v%0d flushD", i), hz0.flushD, vecs[i].fD);
            chk($sformatf("v%0d flushE", i), hz0.flushE, vecs[i].fE);
            chk($sformatf("v%0d stallM", i), hz0.stallM, 0);
            chk($sformatf("v%0d flushW", i), hz0.flushW, 0);
            chk($sformatf("v%0d nofwd stallF", i), hz1.stallF, vecs[i].s1);
            chk($sformatf("v%0d nofwd stallD", i), hz1.stallD, vecs[i].s1);
            chk($sformatf("v%0d nofwd forwardAE", i), hz1.forwardAE, 0);
            if (vecs[i].sF) exp_stall++;
            if (vecs[i].fD) exp_flush++;
            next_cycle();
        end
        chk_counters("table");

        // Load-use: exactly one bubble
        drive(vecs[4]);
        @(negedge clk);
        chk("loaduse stallF", hz0.stallF, 1);
        exp_stall++;
        next_cycle();
        drive(vecs[2]);
        @(negedge clk);
        chk("loaduse released", hz0.stallF, 0);
        next_cycle();
        chk_counters("loaduse");

        // Memory wait with pending taken branch; ack after 4 stall cycles
        drive(vecs[11]);
        set_mem(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("memwait%0d stallF", i), hz0.stallF, 1);
            chk($sformatf("memwait%0d stallM", i), hz0.stallM, 1);
            chk($sformatf("memwait%0d flushW", i), hz0.flushW, 1);
            chk($sformatf("memwait%0d flushE", i), hz0.flushE, 0);
            exp_stall++;
            next_cycle();
        end
        set_mem(1'b1, 1'b1);
        @(negedge clk);
        chk("memack stallF", hz0.stallF, 0);
        chk("memack flushD", hz0.flushD, 1);
        chk("memack flushE", hz0.flushE, 1);
        exp_flush++;
        next_cycle();
        drive(vecs[2]);
        set_mem(1'b0, 1'b0);
        chk_counters("memack");

        // Ack together with request: no stall
        set_mem(1'b1, 1'b1);
        @(negedge clk);
        chk("sameack stallF", hz0.stallF, 0);
        next_cycle();

        // Timeout: 4 stall cycles, release, then one-cycle mem_err
        set_mem(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tmo%0d stallF", i), hz0.stallF, 1);
            exp_stall++;
            next_cycle();
        end
        @(negedge clk);
        chk("tmo release stallF", hz0.stallF, 0);
        chk("tmo mem_err early", hz0.mem_err, 0);
        next_cycle();
        set_mem(1'b0, 1'b0);
        @(negedge clk);
        chk("tmo mem_err pulse", hz0.mem_err, 1);
        next_cycle();
        @(negedge clk);
        chk("tmo mem_err end", hz0.mem_err, 0);
        next_cycle();
        chk_counters("tmo");

        // Reset in the middle of a memory wait
        set_mem(1'b1, 1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        drive(mkv(0, 7, 5, 0, 7, 5, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("midrst stallF", hz0.stallF, 0);
        chk("midrst stallM", hz0.stallM, 0);
        chk("midrst flushD", hz0.flushD, 0);
        chk("midrst flushW", hz0.flushW, 0);
        chk("midrst forwardAE", hz0.forwardAE, 0);
        chk("midrst nofwd stallF", hz1.stallF, 0);
        next_cycle();
        exp_stall = 0;
        exp_flush = 0;
        chk("midrst mem_err", hz0.mem_err, 0);
        chk_counters("midrst");
        rst = 1'b1;
        drive(vecs[2]);
        // A fresh wait from RUN must last the full timeout again
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d stallF", i), hz0.stallF, 1);
            exp_stall++;
            next_cycle();
        end
        @(negedge clk);
        chk("postrst release stallF", hz0.stallF, 0);
        next_cycle();
        set_mem(1'b0, 1'b0);
        @(negedge clk);
        chk("postrst mem_err", hz0.mem_err, 1);
        next_cycle();
        chk_counters("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage RV32I pipeline, succeeding the forwarding-only hazard unit. It drives forwarding selects, adds load-use stalls and branch flushes, and holds the pipeline while a variable-latency data memory completes its handshake, with a timeout. A `FWD_EN` mode replaces forwarding with stall-only interlocking. Saturating stall and flush counters are provided for performance measurement.

## Interface
- `REG_AW`, 5: register address width.
- `FWD_EN`, 1: 1 resolves RAW hazards by forwarding; 0 resolves them by stalling only.
- `MEM_TIMEOUT`, 16: maximum number of wait cycles before a memory access is abandoned. Must be ≥ 2.
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `raddr1D`, `raddr2D`  in  REG_AW  source register addresses in decode.
- `raddr1E`, `raddr2E`  in  REG_AW  source register addresses in execute.
- `waddrE`, `waddrM`, `waddrW`  in  REG_AW  destination register addresses per stage.
- `reg_wrE`, `reg_wrM`, `reg_wrW`  in  1  register write enables per stage.
- `is_loadE`  in  1  execute-stage instruction is a load.
- `br_takenE`  in  1  branch or jump resolved taken in execute.
- `mem_reqM`  in  1  memory-stage access request.
- `mem_ack`  in  1  data memory completion.
- `forwardAE`, `forwardBE`  out  2  forwarding select: 00 = register file, 01 = `wdata` (W), 10 = `ALUResultM`.
- `stallF`, `stallD`, `stallE`, `stallM`  out  1  hold the PC or the pipeline register feeding that stage.
- `flushD`, `flushE`, `flushW`  out  1  load a bubble into that stage's pipeline register.
- `mem_err`  out  1  one-cycle pulse after an access is abandoned on timeout.
- `stall_cycles`, `flush_events`  out  CNT_W  saturating performance counters.

## Operation
**Forwarding** (only when `FWD_EN`=1; otherwise the selects are held at 00):
- A source address of 0 never forwards.
- Select 10 when `reg_wrM` is set and `waddrM` equals the source address.
- Otherwise select 01 when `reg_wrW` is set and `waddrW` equals the source address.
- M has priority over W.

**RAW stall conditions** (`rawD`):
- Load-use, both modes: `is_loadE && reg_wrE && waddrE!=0 && waddrE ∈ {raddr1D, raddr2D}`.
- `FWD_EN`=0 additionally: any nonzero `raddr1D`/`raddr2D` matching a writing E, M or W destination. The register file has no write-through.

**Branch flush:** `br_takenE` asserts `flushD` and `flushE`.

**FSM states:** RUN, MEM_WAIT.
- RUN → MEM_WAIT when `mem_reqM && !mem_ack`. `wait_cnt` is set to 1.
- MEM_WAIT, `mem_ack`=1 → RUN.
- MEM_WAIT, no ack and `wait_cnt` < `MEM_TIMEOUT` → stay and increment `wait_cnt`.
- MEM_WAIT, no ack and `wait_cnt` = `MEM_TIMEOUT` → RUN (abandon). `mem_err` is set for the next cycle. Load data is undefined.

**Memory stall** (`memstall` = `mem_reqM && !mem_ack && !abandon`):
- Asserts `stallF`, `stallD`, `stallE`, `stallM` and `flushW`.

**Priority:** memstall > branch flush > `rawD`.
- During memstall: `flushD`/`flushE` are 0. `br_takenE` stays valid because E is held, and it flushes once the stall releases.
- Branch flush with `rawD`: only the flush is applied. The stalled instruction is squashed anyway.
- `rawD` alone: `stallF`, `stallD`, `flushE`.

**Counters:**
- `stall_cycles` increments each cycle `stallF`=1.
- `flush_events` increments each cycle a branch flush is applied.
- Both saturate at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current state, valid in the same cycle.
- `mem_err`, the counters and the FSM are registered.
- Load-use costs exactly 1 bubble. Taken branch: 2 squashed instructions.
- A `MEM_TIMEOUT` expiry yields exactly `MEM_TIMEOUT` stall cycles.
- Reset (`rst`=0 at a clock edge):
  - Registered state: RUN, `wait_cnt`=0, counters 0, `mem_err`=0.
  - Combinational outputs are forced to 0 while `rst`=0, including mid-MEM_WAIT.
- Ack in the same cycle as the request: no stall and no state change.

## Structure
- Shared package `hazard_pkg`:
  - `fwd_sel_e` (FWD_RF=00, FWD_W=01, FWD_M=10).
  - `hz_state_e` (RUN, MEM_WAIT).
- One sub-module, `fwd_select`, instantiated twice (sources A and B). It compares one source address against M/W and returns `fwd_sel_e`.

## Test plan
- `FWD_EN`=1:
  - `raddr1E`=5, `waddrM`=5 (`reg_wrM`=1), `waddrW`=5 (`reg_wrW`=1) → `forwardAE`=10.
  - Same with `reg_wrM`=0 → 01.
  - `raddr1E`=0 → 00.
- Load-use: `is_loadE`=1, `waddrE`=7, `raddr2D`=7 → one cycle of `stallF`=`stallD`=`flushE`=1. `stall_cycles` increments by 1.
- `FWD_EN`=0, `waddrW`=3 writing, `raddr1D`=3 → `stallF`/`stallD` asserted, `forwardAE`=00.
- `mem_reqM`=1, `mem_ack` arriving 4 cycles later with `br_takenE`=1 throughout → 4 stall cycles with `flushE`=0, then the flush fires on the release cycle and `flush_events`=1.
- `MEM_TIMEOUT`=4, no ack → stalls for 4 cycles, then released, `mem_err` pulses 1 cycle. Reset asserted mid-wait → outputs 0 and FSM in RUN.
